// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer
// Captures an 8-bin FFT frame in one cycle into a two-bank ping-pong buffer
// and streams the bins one per beat on valid/ready, in natural bin order.
module fft_frame_serializer #(
    parameter int DW     = 8,
    parameter bit BITREV = 1'b1
) (
    input  logic          clk_1,
    input  logic          rst_n,
    input  logic          frame_valid,
    output logic          frame_ready,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    input  logic [DW-1:0] in5,
    input  logic [DW-1:0] in6,
    input  logic [DW-1:0] in7,
    input  logic [DW-1:0] in8,
    output logic [DW-1:0] m_data,
    output logic [2:0]    m_index,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [7:0]    frames_dropped
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] slot_in [8];
    logic [DW-1:0] bank    [2][8];

    logic          wr_ptr;
    logic          rd_ptr;
    logic          rd_ptr_nxt;
    logic [1:0]    occ;
    logic [1:0]    occ_nxt;
    logic [2:0]    beat;
    logic [2:0]    beat_nxt;
    logic [2:0]    rd_slot;
    logic [DW-1:0] data_nxt;

    logic          capture;
    logic          drop;
    logic          xfer;
    logic          last_xfer;

    // Slot k of a bit-reversed frame carries bin bitrev3(k), and vice versa.
    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Gather the parallel FFT slots into an indexable array.
    always_comb begin
        slot_in[0] = in1;
        slot_in[1] = in2;
        slot_in[2] = in3;
        slot_in[3] = in4;
        slot_in[4] = in5;
        slot_in[5] = in6;
        slot_in[6] = in7;
        slot_in[7] = in8;
    end

    // frame_ready depends on registered occupancy only, never on m_ready.
    assign frame_ready = (occ != 2'd2);
    assign capture     = frame_valid && frame_ready;
    assign drop        = frame_valid && !frame_ready;
    assign xfer        = (state == STREAM) && m_ready;
    assign last_xfer   = xfer && (beat == 3'd7);

    // Next-state values for occupancy, read position and the presented beat.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        occ_nxt    = occ;
        beat_nxt   = beat;
        rd_ptr_nxt = rd_ptr;
        data_nxt   = '0;

        if (capture && !last_xfer) begin
            occ_nxt = occ + 2'd1;
        end else if (!capture && last_xfer) begin
            occ_nxt = occ - 2'd1;
        end

        if (xfer) begin
            beat_nxt = beat + 3'd1;
        end
        if (last_xfer) begin
            rd_ptr_nxt = ~rd_ptr;
        end

        state_nxt = (occ_nxt != 2'd0) ? STREAM : IDLE;
        rd_slot   = BITREV ? bitrev3(beat_nxt) : beat_nxt;

        // A bank being captured this edge and read next cycle is taken
        // straight from the inputs, giving one-cycle capture-to-valid latency.
        if (capture && (rd_ptr_nxt == wr_ptr)) begin
            data_nxt = slot_in[rd_slot];
        end else begin
            data_nxt = bank[rd_ptr_nxt][rd_slot];
        end
    end

    // Bank storage: written only on capture, into the bank not being streamed.
    // NOTE: the sample memory has no reset; occ and the pointers decide what is
    // valid, so clearing the data would only cost logic.
    always_ff @(posedge clk_1) begin
        if (capture) begin
            for (int i = 0; i < 8; i++) begin
                bank[wr_ptr][i] <= slot_in[i];
            end
        end
    end

    // Control FSM, pointers, drop counter and registered stream outputs.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            occ            <= 2'd0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            beat           <= 3'd0;
            m_valid        <= 1'b0;
            m_data         <= '0;
            m_index        <= 3'd0;
            m_last         <= 1'b0;
            frames_dropped <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state   <= state_nxt;
            occ     <= occ_nxt;
            rd_ptr  <= rd_ptr_nxt;
            beat    <= beat_nxt;
            if (capture) begin
                wr_ptr <= ~wr_ptr;
            end
            if (drop && (frames_dropped != 8'hFF)) begin
                frames_dropped <= frames_dropped + 8'd1;
            end

            m_valid <= (state_nxt == STREAM);
            if (state_nxt == STREAM) begin
                m_data  <= data_nxt;
                m_index <= beat_nxt;
                m_last  <= (beat_nxt == 3'd7);
            end else begin
                m_data  <= '0;
                m_index <= 3'd0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule
